// File: rtl/rxmac_to_ll_fifo.sv
// Rx MAC byte stream to LocalLink bridge. A small first-word-fall-through FIFO absorbs
// LocalLink backpressure; overruns and MAC errors close the frame with an error EOF.
module rxmac_to_ll_fifo #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DWIDTH-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_error,
    input  logic              rx_ack,
    output logic [DWIDTH-1:0] ll_data,
    output logic              ll_sof,
    output logic              ll_eof,
    output logic              ll_error,
    output logic              ll_src_rdy,
    input  logic              ll_dst_rdy,
    output logic [AWIDTH:0]   fifo_level,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  ovr_cnt
);

    localparam int EW = DWIDTH + 3;
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] FULL_LVL = {1'b1, {AWIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_TERM   = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    logic [EW-1:0]     mem_r [0:DEPTH-1];
    logic [AWIDTH-1:0] wr_ptr_r;
    logic [AWIDTH-1:0] rd_ptr_r;
    logic [AWIDTH:0]   level_r;
    state_t            state_r;
    state_t            state_nxt_s;

    logic              srst_s;
    logic              full_s;
    logic              empty_s;
    logic              rd_en_s;
    logic              wr_en_s;
    logic [EW-1:0]     wr_word_s;
    logic [EW-1:0]     head_s;
    logic              inc_frame_s;
    logic              inc_err_s;
    logic              inc_ovr_s;
    logic [CNT_W-1:0]  frame_cnt_r;
    logic [CNT_W-1:0]  err_cnt_r;
    logic [CNT_W-1:0]  ovr_cnt_r;

    // Entry layout, MSB first: sof, eof, err, data.
    function automatic logic [EW-1:0] pack_entry(
        input logic              sof,
        input logic              eof,
        input logic              err,
        input logic [DWIDTH-1:0] data
    );
        pack_entry = {sof, eof, err, data};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic             inc
    );
        if (inc && (cnt != {CNT_W{1'b1}})) begin
            sat_inc = cnt + CNT_W'(1);
        end else begin
            sat_inc = cnt;
        end
    endfunction

    assign srst_s  = reset | clear;
    assign full_s  = (level_r == FULL_LVL);
    assign empty_s = (level_r == {(AWIDTH+1){1'b0}});
    assign rd_en_s = ~empty_s & ll_dst_rdy;
    assign head_s  = mem_r[rd_ptr_r];

    // Frame FSM: next state, FIFO write request and counter increments.
    always_comb begin
        state_nxt_s = state_r;
        wr_en_s     = 1'b0;
        wr_word_s   = {EW{1'b0}};
        inc_frame_s = 1'b0;
        inc_err_s   = 1'b0;
        inc_ovr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid && !full_s) begin
                    wr_en_s   = 1'b1;
                    wr_word_s = pack_entry(1'b1, rx_ack, 1'b0, rx_data);
                    if (rx_ack) begin
                        inc_frame_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_ACTIVE;
                    end
                end else if (rx_valid) begin
                    inc_ovr_s   = 1'b1;
                    state_nxt_s = ST_DROP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (rx_error || !rx_valid) begin
                    inc_err_s   = 1'b1;
                    state_nxt_s = ST_TERM;
                end else if (full_s) begin
                    inc_ovr_s   = 1'b1;
                    state_nxt_s = ST_TERM;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_word_s = pack_entry(1'b0, rx_ack, 1'b0, rx_data);
                    if (rx_ack) begin
                        inc_frame_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_ACTIVE;
                    end
                end
            end
            ST_TERM: begin
                // The closing error EOF waits for space; a read in the full cycle does not help.
                if (!full_s) begin
                    wr_en_s     = 1'b1;
                    wr_word_s   = pack_entry(1'b0, 1'b1, 1'b1, {DWIDTH{1'b0}});
                    state_nxt_s = ST_DROP;
                end else begin
                    state_nxt_s = ST_TERM;
                end
            end
            ST_DROP: begin
                if (!rx_valid && !rx_error) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (srst_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (srst_s) begin
            wr_ptr_r <= {AWIDTH{1'b0}};
            rd_ptr_r <= {AWIDTH{1'b0}};
            level_r  <= {(AWIDTH+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AWIDTH'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AWIDTH'(1);
            end
            level_r <= level_r + {{AWIDTH{1'b0}}, wr_en_s} - {{AWIDTH{1'b0}}, rd_en_s};
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_word_s;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (srst_s) begin
            frame_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
            ovr_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            frame_cnt_r <= sat_inc(frame_cnt_r, inc_frame_s);
            err_cnt_r   <= sat_inc(err_cnt_r, inc_err_s);
            ovr_cnt_r   <= sat_inc(ovr_cnt_r, inc_ovr_s);
        end
    end

    assign ll_data    = head_s[DWIDTH-1:0];
    assign ll_error   = head_s[DWIDTH];
    assign ll_eof     = head_s[DWIDTH+1];
    assign ll_sof     = head_s[DWIDTH+2];
    assign ll_src_rdy = ~empty_s;
    assign fifo_level = level_r;
    assign frame_cnt  = frame_cnt_r;
    assign err_cnt    = err_cnt_r;
    assign ovr_cnt    = ovr_cnt_r;

endmodule
